// File: rtl/rs_pipeline_pkg.sv
// Shared limits and sizing helpers for the elastic relay pipeline and its tail buffer.
package rs_pipeline_pkg;

  localparam int RS_MAX_LEVEL = 8;

  // Free-slot reserve covering a full round trip through the forward and backward register chains.
  function automatic int rs_thresh(input int level);
    return 2 * level + 2;
  endfunction

  function automatic int rs_min_depth(input int level);
    return rs_thresh(level) + 1;
  endfunction

endpackage

// File: rtl/__rs_hs_fwft_buffer.sv
// First-word-fall-through tail buffer with a registered write port and a registered
// low-water full_n, so that in-flight words from the relay chain always find room.
module __rs_hs_fwft_buffer
  import rs_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int THRESH     = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_n_o,
  output logic                  full_n_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] LOW_WATER = CW'(DEPTH - THRESH);

  logic                  wr_vld_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_n_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = wr_vld_q;
  assign do_pop  = pop_i & (count_q != '0);

  // Pointers wrap explicitly so non-power-of-two depths are legal.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_vld_q  <= 1'b0;
      wr_data_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_n_q  <= 1'b0;
    end else begin
      wr_vld_q  <= push_i;
      wr_data_q <= push_data_i;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_n_q  <= (count_d <= LOW_WATER);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_q;
    end
  end

  assign dout_o    = mem_q[rd_ptr_q];
  assign empty_n_o = (count_q != '0);
  assign full_n_o  = full_n_q;

  // The reserve must make an overflowing push impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(do_push && !do_pop && (count_q == FULL_CNT)));

endmodule

// File: rtl/__rs_hs_pipeline_relay.sv
// Elastic relay: LEVEL forward stages (valid+data) and LEVEL backward stages (full_n) around a FWFT tail buffer.
// Handshake: a word transfers in when if_write & if_full_n at a rising edge; it pops out when if_read & if_empty_n.
module __rs_hs_pipeline_relay
  import rs_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEVEL      = 2,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
);

  localparam int THRESH = rs_thresh(LEVEL);

  if ((LEVEL < 1) || (LEVEL > RS_MAX_LEVEL)) begin : g_bad_level
    $error("__rs_hs_pipeline_relay: LEVEL must be within 1..8");
  end
  if (DEPTH < rs_min_depth(LEVEL)) begin : g_bad_depth
    $error("__rs_hs_pipeline_relay: DEPTH must be at least 2*LEVEL+3");
  end

  logic                  fwd_vld_q  [LEVEL];
  logic [DATA_WIDTH-1:0] fwd_data_q [LEVEL];
  logic                  bwd_full_n_q [LEVEL];
  logic                  full_n_int;

  // Neither chain ever stalls; the buffer reserve absorbs whatever is still travelling.
  for (genvar k = 0; k < LEVEL; k++) begin : g_stage
    if (k == 0) begin : g_head
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          fwd_vld_q[0]    <= 1'b0;
          fwd_data_q[0]   <= '0;
          bwd_full_n_q[0] <= 1'b0;
        end else begin
          fwd_vld_q[0]    <= if_write & if_full_n;
          fwd_data_q[0]   <= if_din;
          bwd_full_n_q[0] <= full_n_int;
        end
      end
    end else begin : g_link
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          fwd_vld_q[k]    <= 1'b0;
          fwd_data_q[k]   <= '0;
          bwd_full_n_q[k] <= 1'b0;
        end else begin
          fwd_vld_q[k]    <= fwd_vld_q[k-1];
          fwd_data_q[k]   <= fwd_data_q[k-1];
          bwd_full_n_q[k] <= bwd_full_n_q[k-1];
        end
      end
    end
  end

  assign if_full_n = bwd_full_n_q[LEVEL-1];

  __rs_hs_fwft_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .THRESH     (THRESH)
  ) u_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (fwd_vld_q[LEVEL-1]),
    .push_data_i (fwd_data_q[LEVEL-1]),
    .pop_i       (if_read),
    .dout_o      (if_dout),
    .empty_n_o   (if_empty_n),
    .full_n_o    (full_n_int)
  );

endmodule
